mem_access_unit: RTL and testbench

Sits between the processor's MEM stage and the word-wide data memory, which has synchronous registered reads and synchronous writes, both clocked by `clock`. Converts byte-addressed load/store requests into word accesses:
- byte/halfword loads are extracted and sign- or zero-extended;
- byte/halfword stores are done as read-modify-write;
- misaligned or reserved-size accesses are rejected with an error flag and no memory access.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/byte_lane_unit.sv | 42 ++++
 rtl/mem_access_unit.sv | 106 ++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and the alignment check for the byte-addressed memory access unit.
package mem_access_pkg;

    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned STATE_W = 3;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Request attributes latched at accept time.
    typedef struct packed {
        logic              is_store;
        logic [SIZE_W-1:0] size;
        logic              load_unsigned;
        logic [OFF_W-1:0]  offset;
    } req_t;

    // True when the access is misaligned for its size or uses the reserved size.
    function automatic logic access_err(input logic [SIZE_W-1:0] size, input logic [OFF_W-1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: subword load extraction/extension and subword store merging.
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0]       word,
    input  logic [SIZE_W-1:0] size,
    input  logic [OFF_W-1:0]  offset,
    input  logic              load_unsigned,
    input  logic [31:0]       wdata,
    output logic [31:0]       load_c,
    output logic [31:0]       merge_c
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    assign sh   = {offset, 3'b000};
    assign lane = word >> sh;

    // Word size (and the never-merged reserved size) passes the word straight through.
    always_comb begin
        load_c = word;
        mask   = '1;
        case (size)
            SIZE_BYTE: begin
                load_c = {{24{lane[7] & ~load_unsigned}}, lane[7:0]};
                mask   = 32'h0000_00FF << sh;
            end
            SIZE_HALF: begin
                load_c = {{16{lane[15] & ~load_unsigned}}, lane[15:0]};
                mask   = 32'h0000_FFFF << sh;
            end
            default: begin
                load_c = word;
                mask   = '1;
            end
        endcase
        merge_c = (word & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-wide synchronous data memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    output logic                  ready,
    input  logic                  is_store,
    input  logic [SIZE_W-1:0]     size,
    input  logic                  load_unsigned,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    state_t                state;
    state_t                state_n;
    req_t                  req_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  accept_c;
    logic                  req_err_c;
    logic [31:0]           load_c;
    logic [31:0]           merge_c;
    logic                  unused_addr;

    assign unused_addr = ^addr[31:ADDR_WIDTH+2];
    assign accept_c    = req && (state == ST_IDLE);
    assign req_err_c   = access_err(size, addr[1:0]);

    byte_lane_unit u_lanes (
        .word          (mem_q),
        .size          (req_q.size),
        .offset        (req_q.offset),
        .load_unsigned (req_q.load_unsigned),
        .wdata         (data_q),
        .load_c        (load_c),
        .merge_c       (merge_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (req_err_c)                            state_n = ST_RESP;
                    else if (is_store && size == SIZE_WORD)   state_n = ST_WRITE;
                    else                                      state_n = ST_READ;
                end
            end
            ST_READ:  state_n = ST_MERGE;
            ST_MERGE: state_n = req_q.is_store ? ST_WRITE : ST_RESP;
            ST_WRITE: state_n = ST_RESP;
            ST_RESP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Request latch; the merge/format step reuses data_q for the write word and rdata_q for loads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept_c) begin
            req_q   <= '{is_store: is_store, size: size, load_unsigned: load_unsigned, offset: addr[1:0]};
            addr_q  <= addr[ADDR_WIDTH+1:2];
            data_q  <= wdata;
            rdata_q <= '0;
            err_q   <= req_err_c;
        end else if (state == ST_MERGE) begin
            if (req_q.is_store) data_q  <= merge_c;
            else                rdata_q <= load_c;
        end
    end

    assign ready          = (state == ST_IDLE);
    assign done           = (state == ST_RESP);
    assign mem_we         = (state == ST_WRITE);
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign mem_read_addr  = addr_q;
    assign mem_write_addr = addr_q;
    assign mem_data       = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit against a byte-array memory model.
module tb_mem_access_unit;

    localparam int unsigned AW    = 13;
    localparam int unsigned WORDS = 1 << AW;
    localparam int unsigned BYTES = WORDS * 4;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        int          we;
        logic [31:0] waddr;
    } exp_t;

    logic          clock;
    logic          reset_n;
    logic          req;
    logic          ready;
    logic          is_store;
    logic [1:0]    size;
    logic          load_unsigned;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          done;
    logic          err;
    logic [31:0]   rdata;
    logic [AW-1:0] mem_read_addr;
    logic [AW-1:0] mem_write_addr;
    logic [31:0]   mem_data;
    logic          mem_we;
    logic [31:0]   mem_q;

    logic [31:0] mem_array [0:WORDS-1];
    logic [7:0]  ref_mem   [0:BYTES-1];
    exp_t        exp_q[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          n_done = 0;
    int          cyc = 0;
    int          we_seen = 0;
    logic [31:0] we_addr = '0;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req            (req),
        .ready          (ready),
        .is_store       (is_store),
        .size           (size),
        .load_unsigned  (load_unsigned),
        .addr           (addr),
        .wdata          (wdata),
        .done           (done),
        .err            (err),
        .rdata          (rdata),
        .mem_read_addr  (mem_read_addr),
        .mem_write_addr (mem_write_addr),
        .mem_data       (mem_data),
        .mem_we         (mem_we),
        .mem_q          (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: registered read, synchronous write.
    always @(posedge clock) begin
        if (mem_we) mem_array[mem_write_addr] <= mem_data;
        mem_q <= mem_array[mem_read_addr];
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cyc > 60000) begin
            $display("FAIL watchdog cycles=%0d required_below=60000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    // Monitor: every done pops one expected response.
    always @(negedge clock) begin
        if (!reset_n) begin
            we_seen = 0;
        end else begin
            if (mem_we) begin
                we_seen++;
                we_addr = 32'(mem_write_addr);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done actual=done_high expected=no_response at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("err", 32'(err), 32'(e.err));
                    chk("rdata", rdata, e.rdata);
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    chk("we_cycles", 32'(we_seen), 32'(e.we));
                    if (e.we != 0) chk("we_addr", we_addr, e.waddr);
                    n_done++;
                end
                we_seen = 0;
            end
        end
    end

    // Issue one request; the model response is queued when the accept edge is known.
    task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, input logic hold);
        exp_t x;
        int   base;
        int   nb;
        int   waits;
        logic [31:0] v;
        @(negedge clock);
        req = 1'b1; is_store = st; size = sz; load_unsigned = uns; addr = a; wdata = d;
        waits = 0;
        while (!ready) begin
            @(negedge clock);
            waits++;
            if (waits > 20) begin
                chk("ready_timeout", 32'(ready), 32'd1);
                req = 1'b0;
                return;
            end
        end
        base    = int'(a[AW+1:0]);
        nb      = 1 << sz;
        x.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        x.rdata = '0;
        x.we    = 0;
        x.waddr = 32'(a[AW+1:2]);
        x.acc   = cyc + 1;
        if (x.err) begin
            x.lat = 1;
        end else if (st) begin
            for (int i = 0; i < nb; i++) ref_mem[base+i] = d[8*i +: 8];
            x.we  = 1;
            x.lat = (sz == 2'b10) ? 2 : 4;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            x.rdata = v;
            x.lat   = 3;
        end
        exp_q.push_back(x);
        n_acc++;
        @(posedge clock);
        if (!hold) begin
            @(negedge clock);
            req = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic [1:0]  rs;
        for (int w = 0; w < int'(WORDS); w++) begin
            rd = $urandom;
            mem_array[w] = rd;
            for (int b = 0; b < 4; b++) ref_mem[4*w+b] = rd[8*b +: 8];
        end
        reset_n = 1'b0; req = 1'b0; is_store = 1'b0; size = 2'b00;
        load_unsigned = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clock);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_data", mem_data, 32'd0);
        chk("reset_raddr", 32'(mem_read_addr), 32'd0);
        chk("reset_waddr", 32'(mem_write_addr), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Directed cases
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AA, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_1234, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h0A, 32'h1234_5678, 1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
        drain();
        chk("mem_word4", mem_array[4], 32'h8001_1234);

        // Reset during the WRITE of a byte store
        @(negedge clock);
        req = 1'b1; is_store = 1'b1; size = 2'b00; load_unsigned = 1'b0;
        addr = 32'h11; wdata = 32'h0000_0055;
        chk("ready_before_abort", 32'(ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("we_before_abort", 32'(mem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("abort_mem_kept", mem_array[4], ref_word(4));
        chk("abort_ready_after", 32'(ready), 32'd1);

        // req held high, alternating load/store
        for (int i = 0; i < 20; i++) begin
            ra = {$urandom_range(0, 15), 2'b00} + 32'h40;
            do_req(i[0], 2'(i % 3), 1'(i % 5 == 0), ra + 32'(i % 4 == 3 ? 2 : 0), $urandom, 1'b1);
        end
        @(negedge clock);
        req = 1'b0;
        drain();

        // Randomized mix with address wrap and frequent collisions
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[AW+1:5] = '0;
            rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 2'b01) ra[0] = 1'b0;
                if (rs == 2'b10) ra[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom,
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clock);
                req = 1'b0;
            end
        end
        @(negedge clock);
        req = 1'b0;
        drain();
        chk("done_count", 32'(n_done), 32'(n_acc));
        for (int w = 0; w < 16; w++) chk("final_mem", mem_array[w], ref_word(w));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
